argmax_stream_reader: RTL and testbench
=======================================

Name: argmax_stream_reader

Overview:
- Consumer end of the classifier output vector: reads the 16-bit Softmax/FullyConnected result one element per beat over a valid/ready stream.
- Tracks the running maximum and emits the winning class index and its score on a registered valid/ready output.
- Sits after Softmax in the CNN pipeline and reports the final prediction, plus a length-error flag, to the host/test logic.

Parameters:
- NUM_CLASSES, 10, elements per vector (>=2)
- DATA_WIDTH, 16, element width
- IDX_WIDTH, 4, class index width; must satisfy 2**IDX_WIDTH >= NUM_CLASSES

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  element beat valid
- in_ready  output  1  block can accept a beat
- in_data  input  DATA_WIDTH  element value, unsigned
- in_last  input  1  marks final element of vector
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_class  output  IDX_WIDTH  index of maximum element
- out_score  output  DATA_WIDTH  value of maximum element
- out_error  output  1  vector length != NUM_CLASSES
- busy  output  1  at least one element of current vector accepted, result not yet issued

Behaviour:
- Reset (async, any time, including mid-vector or while out_valid is high):
  - state=ACCUM, element count=0, max=0, max_idx=0.
  - out_valid=0, out_class=0, out_score=0, out_error=0, busy=0.
  - Partial vector is discarded.
- States: ACCUM, DONE.
- in_ready = (state==ACCUM), purely from state. in_ready=1 in the first cycle after reset deassertion.
- A beat is accepted when in_valid && in_ready at a rising edge.
- ACCUM, accepted beat with count==0: max<=in_data, max_idx<=0, count<=1.
- ACCUM, accepted beat with count>0:
  - if in_data > max (unsigned, strict): max<=in_data, max_idx<=count.
  - Ties keep the lower index.
- End of vector is either:
  - (a) accepted beat with in_last=1, or
  - (b) accepted beat that is the NUM_CLASSES-th element (count==NUM_CLASSES-1), regardless of in_last.
- On end of vector, at the same edge:
  - out_class/out_score <= winner, with the final beat included in the comparison.
  - out_error <= 1 if (a) occurred with count != NUM_CLASSES-1 (short vector), or if (b) occurred with in_last=0 (overlong vector, truncated). Otherwise 0.
  - out_valid<=1, state<=DONE, count<=0.
- Latency: out_valid is high the cycle after the final accepted beat.
- Overlong case: beats after truncation are not consumed while in DONE. After return to ACCUM they are treated as a new vector.
- DONE: out_valid, out_class, out_score and out_error are held stable until out_valid && out_ready at an edge. Then out_valid<=0 and state<=ACCUM. in_ready is 1 in the following cycle; there is no same-cycle overlap.
- out_class, out_score and out_error keep their last values after the handshake; they are meaningful only while out_valid=1.
- busy = (state==ACCUM && count!=0) || state==DONE.
- in_valid low mid-vector: state is held, no timeout.
- A single-beat vector with in_last=1: out_class=0, out_score=in_data, out_error=1.
- Maximum throughput: one vector per NUM_CLASSES+1 cycles with out_ready tied high.
- Widths: count is IDX_WIDTH bits and never exceeds NUM_CLASSES-1. No arithmetic overflow is possible.

Test Plan:
- Reset, then stream 10 beats [3,9,2,40,7,40,1,0,5,6] with in_last on beat 10, out_ready=1 -> out_valid for exactly 1 cycle, the cycle after beat 10; out_class=3, out_score=40, out_error=0; in_ready=0 during that cycle.
- Same vector with out_ready=0 for 5 cycles -> out_valid and outputs held stable for 5 cycles; in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- Short vector: 4 beats [100,200,50,10] with in_last on beat 4 -> out_class=1, out_score=200, out_error=1.
- Overlong: 12 beats with in_last only on beat 12, values 0..11 -> first result out_class=9, out_score=9, out_error=1. Beats 11-12 then form a second vector -> out_class=1, out_score=11, out_error=1.
- Unsigned compare and ties: all 10 beats = 16'hFFFF -> out_class=0, out_score=16'hFFFF. Vector [16'h8000, 16'h7FFF, ...zeros] -> out_class=0.
- Reset asserted asynchronously after beat 5 of a vector -> all outputs 0 immediately, busy=0. A fresh 10-beat vector afterwards gives a correct, error-free result.

Source files
------------

// File: rtl/argmax_stream_reader.sv
// argmax_stream_reader
// Consumes a classifier output vector one unsigned element per valid/ready
// beat, tracks the running maximum, and presents the winning class index and
// score on a registered valid/ready result port together with a length-error
// flag.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   element beat valid
//   in_ready   block can accept a beat (high whenever accumulating)
//   in_data    element value, unsigned
//   in_last    marks final element of the vector
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   out_class  index of maximum element (lowest index on ties)
//   out_score  value of maximum element
//   out_error  vector length differed from NUM_CLASSES
//   busy       vector in progress or result pending
module argmax_stream_reader #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IDX_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_class,
    output logic [DATA_WIDTH-1:0] out_score,
    output logic                  out_error,
    output logic                  busy
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_WIDTH-1:0]  max_idx_q, max_idx_d;
    logic                  out_valid_d;
    logic [IDX_WIDTH-1:0]  out_class_d;
    logic [DATA_WIDTH-1:0] out_score_d;
    logic                  out_error_d;

    // Winner including the current beat; the first beat always seeds it.
    logic [DATA_WIDTH-1:0] cand_max;
    logic [IDX_WIDTH-1:0]  cand_idx;

    always_comb begin
        cand_max = max_q;
        cand_idx = max_idx_q;
        if (count_q == '0) begin
            cand_max = in_data;
            cand_idx = '0;
        end else if (in_data > max_q) begin
            cand_max = in_data;
            cand_idx = count_q;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        max_d       = max_q;
        max_idx_d   = max_idx_q;
        out_valid_d = out_valid;
        out_class_d = out_class;
        out_score_d = out_score;
        out_error_d = out_error;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    max_d     = cand_max;
                    max_idx_d = cand_idx;
                    if (in_last || (count_q == LAST_IDX)) begin
                        // Short vector ends on in_last early; overlong is cut
                        // at NUM_CLASSES with in_last still low.
                        out_valid_d = 1'b1;
                        out_class_d = cand_idx;
                        out_score_d = cand_max;
                        out_error_d = in_last ? (count_q != LAST_IDX) : 1'b1;
                        state_d     = DONE;
                        count_d     = '0;
                    end else begin
                        count_d = count_q + IDX_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ACCUM;
            count_q   <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            out_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            out_valid <= out_valid_d;
            out_class <= out_class_d;
            out_score <= out_score_d;
            out_error <= out_error_d;
        end
    end

    // Both decoded straight from registered state.
    assign in_ready = (state_q == ACCUM);
    assign busy     = ((state_q == ACCUM) && (count_q != '0)) || (state_q == DONE);

endmodule

// File: tb/tb_argmax_stream_reader.sv
// Self-checking bench for argmax_stream_reader: directed vectors from the
// test plan followed by a randomized beat stream checked against a queue-based
// reference model.
module tb_argmax_stream_reader;

    localparam int unsigned NC = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_class;
    logic [DW-1:0] out_score;
    logic          out_error;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mv[$];

    argmax_stream_reader #(
        .NUM_CLASSES(NC),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_score(out_score),
        .out_error(out_error),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: split the beat stream into vectors, argmax with first-wins ties.
    task automatic model_push(input logic [DW-1:0] d, input logic l, output logic ended,
                              output int cls, output logic [DW-1:0] sc, output logic er);
        ended = 1'b0;
        cls   = 0;
        sc    = '0;
        er    = 1'b0;
        mv.push_back(d);
        if (l || (mv.size() == NC)) begin
            ended = 1'b1;
            sc    = mv[0];
            for (int i = 1; i < mv.size(); i++) begin
                if (mv[i] > sc) begin
                    sc  = mv[i];
                    cls = i;
                end
            end
            er = (mv.size() != NC) || !l;
            mv.delete();
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        @(negedge clk);
    endtask

    // Called at the negedge right after the final beat of a vector.
    task automatic expect_result(input string tag, input int cls, input logic [DW-1:0] sc,
                                 input logic er, input int hold, input logic keep_valid);
        if (!keep_valid) in_valid = 1'b0;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd1);
        chk({tag, "_class"},     32'(out_class), 32'(cls));
        chk({tag, "_score"},     32'(out_score), 32'(sc));
        chk({tag, "_error"},     32'(out_error), 32'(er));
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_class"}, 32'(out_class), 32'(cls));
                chk({tag, "_hold_score"}, 32'(out_score), 32'(sc));
                chk({tag, "_hold_error"}, 32'(out_error), 32'(er));
                chk({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_post_busy"},  32'(busy),      32'd0);
    endtask

    task automatic send_vec(input logic [DW-1:0] v[$], input int last_pos);
        for (int i = 0; i < v.size(); i++) send_beat(v[i], (i == last_pos));
    endtask

    initial begin
        logic [DW-1:0] v[$];
        logic          ended;
        int            mcls;
        logic [DW-1:0] msc;
        logic          mer;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_class",     32'(out_class), 32'd0);
        chk("rst_score",     32'(out_score), 32'd0);
        chk("rst_error",     32'(out_error), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Nominal vector, immediate acceptance
        v = '{3, 9, 2, 40, 7, 40, 1, 0, 5, 6};
        send_vec(v, 9);
        expect_result("nominal", 3, 40, 1'b0, 0, 1'b0);

        // Same vector with downstream stalled five cycles
        send_vec(v, 9);
        expect_result("stall", 3, 40, 1'b0, 5, 1'b0);

        // Short vector
        v = '{100, 200, 50, 10};
        send_vec(v, 3);
        expect_result("short", 1, 200, 1'b1, 0, 1'b0);

        // Overlong: truncated at 10 beats; trailing beat waits through DONE
        for (int i = 0; i < 10; i++) send_beat(DW'(i), 1'b0);
        in_data = DW'(10);
        in_last = 1'b0;
        expect_result("overlong1", 9, 9, 1'b1, 3, 1'b1);
        chk("overlong_no_consume_busy", 32'(busy), 32'd0);
        send_beat(DW'(10), 1'b0);
        send_beat(DW'(11), 1'b1);
        expect_result("overlong2", 1, 11, 1'b1, 0, 1'b0);

        // Single-beat vector
        send_beat(DW'(16'h1234), 1'b1);
        expect_result("single", 0, 16'h1234, 1'b1, 0, 1'b0);

        // Unsigned compare and ties
        for (int i = 0; i < 10; i++) send_beat(16'hFFFF, (i == 9));
        expect_result("all_ffff", 0, 16'hFFFF, 1'b0, 0, 1'b0);
        v = '{16'h8000, 16'h7FFF, 0, 0, 0, 0, 0, 0, 0, 0};
        send_vec(v, 9);
        expect_result("unsigned", 0, 16'h8000, 1'b0, 0, 1'b0);

        // Asynchronous reset mid-vector (outputs still hold previous result)
        v = '{5, 6, 7, 8, 9};
        send_vec(v, -1);
        in_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_class", 32'(out_class), 32'd0);
        chk("async_rst_score", 32'(out_score), 32'd0);
        chk("async_rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", 32'(in_ready), 32'd1);
        v = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
        send_vec(v, 9);
        expect_result("after_rst", 4, 50, 1'b0, 0, 1'b0);

        // Randomized stream vs reference model
        mv.delete();
        for (int n = 0; n < 200; n++) begin
            logic [DW-1:0] d;
            logic          l;
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                chk("rnd_gap_busy", 32'(busy), 32'(mv.size() != 0));
            end
            d = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            l = ($urandom_range(0, 7) == 0);
            send_beat(d, l);
            model_push(d, l, ended, mcls, msc, mer);
            if (ended) begin
                expect_result("rnd", mcls, msc, mer, $urandom_range(0, 3), 1'b0);
            end else begin
                chk("rnd_mid_valid", 32'(out_valid), 32'd0);
                chk("rnd_mid_busy",  32'(busy),      32'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
